// File: rtl/sr_pkg.sv
// Shared definitions for the serial-in/parallel-out receiver and its matching transmitter.
package sr_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RECV = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_RECV = ST_RECV
    } state_t;

    // Bit 0 of a word travels first on the serial line in both directions.
    localparam bit LSB_FIRST = 1'b1;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input, handshake and status bundle of the deserializer.
interface sipo_deserializer_if #(
    parameter int N = 4
) ();
    localparam int CW = sr_pkg::cnt_width(N);

    logic          serial_in;
    logic          bit_valid;
    logic          frame_start;
    logic          word_ready;
    logic          overrun_clr;
    logic [N-1:0]  word_out;
    logic          word_valid;
    logic          overrun;
    logic          busy;
    logic [CW-1:0] bit_cnt;

    modport master (
        output serial_in, bit_valid, frame_start, word_ready, overrun_clr,
        input  word_out, word_valid, overrun, busy, bit_cnt
    );

    modport slave (
        input  serial_in, bit_valid, frame_start, word_ready, overrun_clr,
        output word_out, word_valid, overrun, busy, bit_cnt
    );
endinterface

// File: rtl/sipo_deserializer_shift_core.sv
// N-bit right-shift register with a wrapping bit counter; flags the word-completing bit.
module sipo_shift_core #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          shift_en,
    input  logic          clr,
    input  logic          serial_in,
    output logic [N-1:0]  word_next,
    output logic [CW-1:0] bit_cnt,
    output logic          done
);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [N-1:0] sr;

    assign word_next = {serial_in, sr[N-1:1]};
    // A bit arriving with clr starts a new word, so it can never complete one.
    assign done = shift_en && !clr && (bit_cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            if (shift_en)
                sr <= word_next;
            if (clr)
                bit_cnt <= shift_en ? CW'(1) : '0;
            else if (shift_en)
                bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/sipo_deserializer.sv
// Framed LSB-first serial receiver with a valid/ready holding register and sticky overrun.
//
// state  | meaning
// S_IDLE | waiting for frame_start; stray bits ignored
// S_RECV | collecting bits of the current word
module sipo_deserializer
    import sr_pkg::*;
#(
    parameter int N          = 4,
    parameter bit CONTINUOUS = 1'b0
) (
    input logic               clk,
    input logic               reset_n,
    sipo_deserializer_if.slave bus
);
    localparam int CW = cnt_width(N);

    state_t        state, state_nxt;
    logic          shift_en;
    logic          done;
    logic [N-1:0]  word_next;
    logic [CW-1:0] cnt;
    logic          load_word;
    logic          overrun_set;

    assign shift_en = bus.bit_valid && (state == S_RECV || bus.frame_start);

    sipo_shift_core #(.N(N), .CW(CW)) u_core (
        .clk       (clk),
        .reset_n   (reset_n),
        .shift_en  (shift_en),
        .clr       (bus.frame_start),
        .serial_in (bus.serial_in),
        .word_next (word_next),
        .bit_cnt   (cnt),
        .done      (done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.frame_start) state_nxt = S_RECV;
            S_RECV: if (done && !CONTINUOUS) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A finished word is taken only if the holding register is empty or draining now.
    always_comb begin
        load_word   = 1'b0;
        overrun_set = 1'b0;
        if (done) begin
            if (!bus.word_valid || bus.word_ready)
                load_word = 1'b1;
            else
                overrun_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.word_out   <= '0;
            bus.word_valid <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            if (load_word) begin
                bus.word_out   <= word_next;
                bus.word_valid <= 1'b1;
            end else if (bus.word_valid && bus.word_ready) begin
                bus.word_valid <= 1'b0;
            end

            if (overrun_set)
                bus.overrun <= 1'b1;
            else if (bus.overrun_clr)
                bus.overrun <= 1'b0;
        end
    end

    assign bus.busy    = (state == S_RECV);
    assign bus.bit_cnt = cnt;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: one non-continuous and one continuous instance.
module tb_sipo_deserializer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sipo_deserializer_if #(.N(4)) if0 ();
    sipo_deserializer_if #(.N(4)) if1 ();

    sipo_deserializer #(.N(4), .CONTINUOUS(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    sipo_deserializer #(.N(4), .CONTINUOUS(1'b1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic fs, input logic bv, input logic b,
                          input logic rdy, input logic oclr);
        if0.frame_start = fs;
        if0.bit_valid   = bv;
        if0.serial_in   = b;
        if0.word_ready  = rdy;
        if0.overrun_clr = oclr;
        step();
    endtask

    task automatic drive1(input logic fs, input logic bv, input logic b, input logic rdy);
        if1.frame_start = fs;
        if1.bit_valid   = bv;
        if1.serial_in   = b;
        if1.word_ready  = rdy;
        if1.overrun_clr = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step();
        reset_n = 1'b1;
        checks++;
        if ({if0.word_out, if0.word_valid, if0.overrun, if0.busy, if0.bit_cnt} !== 9'h0) begin
            failures++;
            $display("FAIL reset_init: got out=%h v=%b ov=%b busy=%b cnt=%0d, want all 0",
                     if0.word_out, if0.word_valid, if0.overrun, if0.busy, if0.bit_cnt);
        end
        // Build word_valid=1 with a partial word in flight, then reset asynchronously.
        drive0(1, 1, 1, 0, 0); drive0(0, 1, 0, 0, 0); drive0(0, 1, 1, 0, 0); drive0(0, 1, 1, 0, 0);
        drive0(1, 1, 1, 0, 0); drive0(0, 1, 0, 0, 0);
        checks++;
        if (if0.word_valid !== 1'b1 || if0.busy !== 1'b1 || if0.bit_cnt !== 2'd2) begin
            failures++;
            $display("FAIL reset_setup: got v=%b busy=%b cnt=%0d, want 1 1 2",
                     if0.word_valid, if0.busy, if0.bit_cnt);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({if0.word_out, if0.word_valid, if0.overrun, if0.busy, if0.bit_cnt} !== 9'h0) begin
            failures++;
            $display("FAIL reset_async: got out=%h v=%b ov=%b busy=%b cnt=%0d, want all 0",
                     if0.word_out, if0.word_valid, if0.overrun, if0.busy, if0.bit_cnt);
        end
        if0.frame_start = 0; if0.bit_valid = 0;
        step();
        reset_n = 1'b1;
        drive0(0, 1, 1, 0, 0); drive0(0, 1, 1, 0, 0); drive0(0, 1, 0, 0, 0);
        checks++;
        if (if0.busy !== 1'b0 || if0.bit_cnt !== 2'd0 || if0.word_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ignore_bits: got busy=%b cnt=%0d v=%b, want 0 0 0",
                     if0.busy, if0.bit_cnt, if0.word_valid);
        end
    endtask

    task automatic test_basic();
        drive0(1, 1, 1, 0, 0);
        checks++;
        if (if0.busy !== 1'b1 || if0.bit_cnt !== 2'd1) begin
            failures++;
            $display("FAIL basic_first_bit: got busy=%b cnt=%0d, want 1 1", if0.busy, if0.bit_cnt);
        end
        drive0(0, 1, 0, 0, 0); drive0(0, 1, 1, 0, 0);
        checks++;
        if (if0.word_valid !== 1'b0 || if0.bit_cnt !== 2'd3) begin
            failures++;
            $display("FAIL basic_before_last: got v=%b cnt=%0d, want 0 3", if0.word_valid, if0.bit_cnt);
        end
        drive0(0, 1, 1, 0, 0);
        checks++;
        if (if0.word_out !== 4'hD || if0.word_valid !== 1'b1 || if0.busy !== 1'b0 || if0.bit_cnt !== 2'd0) begin
            failures++;
            $display("FAIL basic_word: got out=%h v=%b busy=%b cnt=%0d, want D 1 0 0",
                     if0.word_out, if0.word_valid, if0.busy, if0.bit_cnt);
        end
        drive0(0, 0, 0, 1, 0);
        checks++;
        if (if0.word_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_consume: got v=%b, want 0", if0.word_valid);
        end
        drive0(0, 0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        drive0(1, 1, 1, 0, 0); drive0(0, 1, 0, 0, 0); drive0(0, 1, 1, 0, 0); drive0(0, 1, 1, 0, 0);
        drive0(1, 1, 1, 0, 0); drive0(0, 1, 1, 0, 0); drive0(0, 1, 0, 0, 0); drive0(0, 1, 0, 0, 0);
        checks++;
        if (if0.word_out !== 4'hD || if0.word_valid !== 1'b1 || if0.overrun !== 1'b1) begin
            failures++;
            $display("FAIL bp_overrun: got out=%h v=%b ov=%b, want D 1 1",
                     if0.word_out, if0.word_valid, if0.overrun);
        end
        drive0(0, 0, 0, 0, 1);
        checks++;
        if (if0.overrun !== 1'b0 || if0.word_out !== 4'hD) begin
            failures++;
            $display("FAIL bp_clear: got ov=%b out=%h, want 0 D", if0.overrun, if0.word_out);
        end
        // Clear asserted on the very edge of a new overrun: the set must win.
        drive0(1, 1, 0, 0, 0); drive0(0, 1, 1, 0, 0); drive0(0, 1, 1, 0, 0); drive0(0, 1, 0, 0, 1);
        checks++;
        if (if0.overrun !== 1'b1 || if0.word_out !== 4'hD) begin
            failures++;
            $display("FAIL bp_set_wins: got ov=%b out=%h, want 1 D", if0.overrun, if0.word_out);
        end
        drive0(0, 0, 0, 1, 1);
        checks++;
        if (if0.overrun !== 1'b0 || if0.word_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: got ov=%b v=%b, want 0 0", if0.overrun, if0.word_valid);
        end
        drive0(0, 0, 0, 0, 0);
    endtask

    task automatic test_same_edge();
        drive0(1, 1, 1, 0, 0); drive0(0, 1, 0, 0, 0); drive0(0, 1, 1, 0, 0); drive0(0, 1, 1, 0, 0);
        drive0(1, 1, 0, 0, 0); drive0(0, 1, 1, 0, 0); drive0(0, 1, 1, 0, 0); drive0(0, 1, 0, 1, 0);
        checks++;
        if (if0.word_out !== 4'h6 || if0.word_valid !== 1'b1 || if0.overrun !== 1'b0) begin
            failures++;
            $display("FAIL same_edge: got out=%h v=%b ov=%b, want 6 1 0",
                     if0.word_out, if0.word_valid, if0.overrun);
        end
        drive0(0, 0, 0, 1, 0);
        checks++;
        if (if0.word_valid !== 1'b0) begin
            failures++;
            $display("FAIL same_edge_consume: got v=%b, want 0", if0.word_valid);
        end
        drive0(0, 0, 0, 0, 0);
    endtask

    task automatic test_abort();
        drive0(1, 1, 1, 0, 0); drive0(0, 1, 1, 0, 0);
        drive0(1, 1, 0, 0, 0);
        checks++;
        if (if0.bit_cnt !== 2'd1 || if0.busy !== 1'b1 || if0.word_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_restart: got cnt=%0d busy=%b v=%b, want 1 1 0",
                     if0.bit_cnt, if0.busy, if0.word_valid);
        end
        drive0(0, 1, 0, 0, 0); drive0(0, 1, 0, 0, 0);
        checks++;
        if (if0.word_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_partial: got v=%b, want 0", if0.word_valid);
        end
        drive0(0, 1, 1, 0, 0);
        checks++;
        if (if0.word_out !== 4'h8 || if0.word_valid !== 1'b1 || if0.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_word: got out=%h v=%b busy=%b, want 8 1 0",
                     if0.word_out, if0.word_valid, if0.busy);
        end
        drive0(0, 0, 0, 1, 0);
        drive0(0, 0, 0, 0, 0);
    endtask

    task automatic test_continuous();
        logic [7:0] bits;
        int busy_errs;
        bits = 8'b1110_0001;   // sent LSB first: 1,0,0,0,0,1,1,1
        busy_errs = 0;
        for (int i = 0; i < 8; i++) begin
            drive1((i == 0), 1, bits[i], 1);
            if (if1.busy !== 1'b1) busy_errs++;
            if (i == 3) begin
                checks++;
                if (if1.word_out !== 4'h1 || if1.word_valid !== 1'b1 || if1.bit_cnt !== 2'd0) begin
                    failures++;
                    $display("FAIL cont_word1: got out=%h v=%b cnt=%0d, want 1 1 0",
                             if1.word_out, if1.word_valid, if1.bit_cnt);
                end
            end
        end
        checks++;
        if (if1.word_out !== 4'hE || if1.word_valid !== 1'b1 || if1.overrun !== 1'b0) begin
            failures++;
            $display("FAIL cont_word2: got out=%h v=%b ov=%b, want E 1 0",
                     if1.word_out, if1.word_valid, if1.overrun);
        end
        checks++;
        if (busy_errs != 0) begin
            failures++;
            $display("FAIL cont_busy: got %0d cycles with busy=0, want 0", busy_errs);
        end
        drive1(0, 0, 0, 0);
    endtask

    initial begin
        if0.frame_start = 0; if0.bit_valid = 0; if0.serial_in = 0; if0.word_ready = 0; if0.overrun_clr = 0;
        if1.frame_start = 0; if1.bit_valid = 0; if1.serial_in = 0; if1.word_ready = 0; if1.overrun_clr = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_same_edge();
        test_abort();
        test_continuous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
